im_fetch_ctrl: RTL and testbench
================================

// Module: im_fetch_ctrl
// PURPOSE
//  Sequencer for the instruction memory (IM, word-addressed by instrAddr[13:2]).
//  After reset it boot-loads program words into IM through a valid/ready stream,
//  then owns the PC: drives IM read address, computes next PC, handles stall/halt.
//  Sits between loader/decoder and IM in the single-cycle CPU.
// PARAMETERS
//  PC_RESET   32'h0000_3000  PC value on entering RUN
//  IM_BASE    32'h0000_3000  byte address mapped to IM word 0
//  IM_ADDR_W  12             IM word-address width (4096 words)
//  HALT_WORD  32'h0000_000C  instruction encoding that halts fetch
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   synchronous, active-high
//  loadValid    in   1   loader word valid
//  loadReady    out  1   controller accepts loader word
//  loadData     in   32  loader word
//  loadLast     in   1   accepted word is the last of the image
//  imWe         out  1   IM write enable
//  imWaddr      out  12  IM write word address
//  imWdata      out  32  IM write data
//  instrAddr    out  12  IM read word address (IM port [13:2])
//  instr        in   32  IM read data
//  pc           out  32  current PC
//  fetchValid   out  1   instr is a valid fetched instruction this cycle
//  stall        in   1   hold PC this cycle
//  npcSel       in   2   00 pc+4, 01 branch, 10 j/jal, 11 jr
//  branchTaken  in   1   branch condition (npcSel==01 only)
//  branchOff    in   16  branch offset in words, signed
//  jumpIndex    in   26  j/jal index
//  jrTarget     in   32  jr target byte address
//  halted       out  1   state == HALT
//  addrErr      out  1   sticky: halted due to bad target
// BEHAVIOUR
//  States BOOT, RUN, HALT; reset -> BOOT, pc=PC_RESET, wcnt=0, addrErr=0.
//  While reset high: loadReady=0, imWe=0, fetchValid=0, halted=0.
//  BOOT: loadReady=1; imWe=loadValid&loadReady; imWaddr=wcnt; imWdata=loadData.
//   Each accepted word: wcnt+1. loadLast counts only on an accepted word.
//   Accepted word with loadLast, or accepted word at wcnt==2^IM_ADDR_W-1 -> RUN
//   next cycle (that word is still written); pc=PC_RESET on entry to RUN.
//  RUN: fetchValid=1, loadReady=0, imWe=0; instrAddr=(pc-IM_BASE)[13:2] comb.
//   stall=1: pc holds, no halt check. stall=0: pc<=npc, 1 cycle latency.
//   npc: 00 pc+4; 01 taken ? pc+4+(sext(branchOff)<<2) : pc+4;
//        10 {pc[31:28],jumpIndex,2'b00}; 11 jrTarget. 32-bit wrap arithmetic.
//   Bad npc (npc<IM_BASE, npc>=IM_BASE+4*2^IM_ADDR_W, or npc[1:0]!=0):
//    -> HALT, addrErr=1, pc holds old value.
//   instr==HALT_WORD, stall=0: -> HALT, pc holds (halt beats bad npc; addrErr=0).
//  HALT: halted=1, fetchValid=0, all writes off, pc frozen; exit only by reset.
//  Reset mid-BOOT/RUN: back to BOOT, wcnt=0; IM contents not cleared.
// TESTING
//  Load 3 words w/ loadLast on 3rd -> imWaddr 0,1,2, imWe 3 cycles; RUN, pc=3000.
//  RUN, npcSel=00, 3 cycles -> pc 3000,3004,3008; instrAddr 0,1,2.
//  pc=3008, npcSel=01, taken, off=FFFF -> pc stays 3008; not taken -> 300C.
//  stall=1 for 2 cycles -> pc constant; then stall=0, npcSel=10, index=0C01 -> 3004.
//  npcSel=11, jrTarget=2FFC -> halted=1, addrErr=1, pc unchanged.
//  instr=0000000C, stall=0 -> HALT next cycle; reset after 2 BOOT words -> wcnt 0.

Source files
------------

// File: rtl/im_fetch_ctrl_if.sv
// Bundle of loader, IM write/read, and decoder-side signals for the fetch controller.
// Latency: none; this is wiring only.
// Backpressure: the loader stream uses loadValid/loadReady; all other signals are unthrottled.
interface im_fetch_ctrl_if #(
   parameter int IM_ADDR_W = 12
);
   // Loader stream
   logic                 loadValid;
   logic                 loadReady;
   logic [31:0]          loadData;
   logic                 loadLast;

   // IM write port
   logic                 imWe;
   logic [IM_ADDR_W-1:0] imWaddr;
   logic [31:0]          imWdata;

   // IM read port
   logic [IM_ADDR_W-1:0] instrAddr;
   logic [31:0]          instr;

   // PC and fetch status
   logic [31:0]          pc;
   logic                 fetchValid;
   logic                 halted;
   logic                 addrErr;

   // Next-PC controls from the decoder
   logic                 stall;
   logic [1:0]           npcSel;
   logic                 branchTaken;
   logic [15:0]          branchOff;
   logic [25:0]          jumpIndex;
   logic [31:0]          jrTarget;

   // Controller side
   modport master (
      input  loadValid, loadData, loadLast,
      output loadReady,
      output imWe, imWaddr, imWdata,
      output instrAddr,
      input  instr,
      output pc, fetchValid, halted, addrErr,
      input  stall, npcSel, branchTaken, branchOff, jumpIndex, jrTarget
   );

   // Loader / IM / decoder side
   modport slave (
      output loadValid, loadData, loadLast,
      input  loadReady,
      input  imWe, imWaddr, imWdata,
      input  instrAddr,
      output instr,
      input  pc, fetchValid, halted, addrErr,
      output stall, npcSel, branchTaken, branchOff, jumpIndex, jrTarget
   );
endinterface

// File: rtl/im_fetch_ctrl.sv
// Instruction-memory sequencer: boot-loads IM from a stream, then owns the PC and fetch address.
// Latency: one loader word per cycle in BOOT; PC updates one cycle after the npc controls are presented.
// Backpressure: loadReady is high only in BOOT; stall holds the PC; HALT is left only by reset.
module im_fetch_ctrl #(
   parameter logic [31:0] PC_RESET  = 32'h0000_3000,
   parameter logic [31:0] IM_BASE   = 32'h0000_3000,
   parameter int          IM_ADDR_W = 12,
   parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
   input logic            clk_i,
   input logic            reset_i,
   im_fetch_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   // First byte address past the end of IM; 33 bits so the sum cannot wrap.
   localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'd4 << IM_ADDR_W);

   state_t               state_q, state_d;
   logic [31:0]          pc_q, pc_d;
   logic [IM_ADDR_W-1:0] wcnt_q, wcnt_d;
   logic                 addr_err_q, addr_err_d;

   logic                 load_acc;
   logic [31:0]          seq_pc;
   logic [31:0]          br_off;
   logic [31:0]          npc;
   logic                 npc_bad;

   // Next-PC selection and target legality check (all 32-bit wrap arithmetic).
   always_comb begin
      seq_pc = pc_q + 32'd4;
      br_off = {{14{bus.branchOff[15]}}, bus.branchOff, 2'b00};
      npc    = seq_pc;
      case (bus.npcSel)
         2'b00:   npc = seq_pc;
         2'b01:   npc = bus.branchTaken ? (seq_pc + br_off) : seq_pc;
         2'b10:   npc = {pc_q[31:28], bus.jumpIndex, 2'b00};
         default: npc = bus.jrTarget;
      endcase
      npc_bad = (npc < IM_BASE) || ({1'b0, npc} >= IM_END) || (npc[1:0] != 2'b00);
   end

   // A loader word is taken only in BOOT and never while reset is asserted.
   assign load_acc = bus.loadValid && (state_q == ST_BOOT) && !reset_i;

   // Next-state logic: boot word counting, PC advance, and the two halt causes.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      wcnt_d     = wcnt_q;
      addr_err_d = addr_err_q;
      case (state_q)
         ST_BOOT: begin
            if (load_acc) begin
               wcnt_d = wcnt_q + 1'b1;
               // The last word of the image, or the word filling IM, ends the boot.
               if (bus.loadLast || (wcnt_q == {IM_ADDR_W{1'b1}})) begin
                  state_d = ST_RUN;
                  pc_d    = PC_RESET;
               end
            end
         end
         ST_RUN: begin
            if (!bus.stall) begin
               // A halt instruction takes priority over a bad target and is not an error.
               if (bus.instr == HALT_WORD) begin
                  state_d = ST_HALT;
               end else if (npc_bad) begin
                  state_d    = ST_HALT;
                  addr_err_d = 1'b1;
               end else begin
                  pc_d = npc;
               end
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // State registers with synchronous reset; IM contents are not touched by reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_BOOT;
         pc_q       <= PC_RESET;
         wcnt_q     <= '0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         wcnt_q     <= wcnt_d;
         addr_err_q <= addr_err_d;
      end
   end

   // Output decode; handshake and status outputs are forced low while reset is high.
   always_comb begin
      bus.loadReady  = (state_q == ST_BOOT) && !reset_i;
      bus.imWe       = load_acc;
      bus.imWaddr    = wcnt_q;
      bus.imWdata    = bus.loadData;
      bus.instrAddr  = IM_ADDR_W'((pc_q - IM_BASE) >> 2);
      bus.pc         = pc_q;
      bus.fetchValid = (state_q == ST_RUN) && !reset_i;
      bus.halted     = (state_q == ST_HALT) && !reset_i;
      bus.addrErr    = addr_err_q;
   end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Self-checking bench for im_fetch_ctrl: directed table, full-IM boot, and randomized run.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: the bench is the loader and decoder, so it observes loadReady and drives stall.
module tb_im_fetch_ctrl;

   localparam logic [31:0] PC_RESET  = 32'h0000_3000;
   localparam logic [31:0] IM_BASE   = 32'h0000_3000;
   localparam int          IM_WORDS  = 4096;
   localparam logic [31:0] HALT_WORD = 32'h0000_000C;
   localparam bit N = 1'b0;
   localparam bit Y = 1'b1;

   logic clk;
   logic rst;

   im_fetch_ctrl_if #(.IM_ADDR_W(12)) bus ();

   im_fetch_ctrl #(
      .PC_RESET (PC_RESET),
      .IM_BASE  (IM_BASE),
      .IM_ADDR_W(12),
      .HALT_WORD(HALT_WORD)
   ) dut (
      .clk_i  (clk),
      .reset_i(rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // ctl = {reset, loadValid, loadLast, stall, branchTaken}; ex = {loadReady, imWe, fetchValid, halted, addrErr}
   typedef struct {
      logic [4:0]  ctl;
      logic [1:0]  sel;
      logic [15:0] off;
      logic [25:0] idx;
      logic [31:0] jr;
      logic [31:0] ins;
      logic [4:0]  ex;
      logic [11:0] wa;
      logic [31:0] pc;
      bit          cpc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(logic [4:0] ctl, logic [1:0] sel, logic [15:0] off, logic [25:0] idx,
                              logic [31:0] jr, logic [31:0] ins, logic [4:0] ex, logic [11:0] wa,
                              logic [31:0] pc, bit cpc);
      vec_t r;
      r.ctl = ctl; r.sel = sel; r.off = off; r.idx = idx; r.jr = jr; r.ins = ins;
      r.ex = ex; r.wa = wa; r.pc = pc; r.cpc = cpc;
      return r;
   endfunction

   task automatic drive(bit r, bit lv, logic [31:0] ld, bit ll, bit st, logic [1:0] sel, bit tk,
                        logic [15:0] off, logic [25:0] idx, logic [31:0] jr, logic [31:0] ins);
      rst             = r;
      bus.loadValid   = lv;
      bus.loadData    = ld;
      bus.loadLast    = ll;
      bus.stall       = st;
      bus.npcSel      = sel;
      bus.branchTaken = tk;
      bus.branchOff   = off;
      bus.jumpIndex   = idx;
      bus.jrTarget    = jr;
      bus.instr       = ins;
   endtask

   task automatic chk(string nm, bit e_lr, bit e_we, logic [11:0] e_wa, logic [31:0] e_wd,
                      bit e_fv, bit e_h, bit e_ae, logic [31:0] e_pc, bit c_pc);
      bit bad;
      logic [11:0] e_ia;
      bad  = 1'b0;
      e_ia = 12'((e_pc - IM_BASE) >> 2);
      vectors++;
      if (bus.loadReady !== e_lr || bus.imWe !== e_we || bus.fetchValid !== e_fv || bus.halted !== e_h)
         bad = 1'b1;
      if (e_lr && bus.imWaddr !== e_wa) bad = 1'b1;
      if (e_we && bus.imWdata !== e_wd) bad = 1'b1;
      if (c_pc && (bus.pc !== e_pc || bus.addrErr !== e_ae || bus.instrAddr !== e_ia)) bad = 1'b1;
      if (bad) begin
         miscompares++;
         $display("FAIL %s: got lr=%b we=%b wa=%h wd=%h fv=%b h=%b ae=%b pc=%h ia=%h; want lr=%b we=%b wa=%h wd=%h fv=%b h=%b ae=%b pc=%h ia=%h (pc/ae/ia checked=%b)",
                  nm, bus.loadReady, bus.imWe, bus.imWaddr, bus.imWdata, bus.fetchValid, bus.halted,
                  bus.addrErr, bus.pc, bus.instrAddr, e_lr, e_we, e_wa, e_wd, e_fv, e_h, e_ae, e_pc, e_ia, c_pc);
      end
   endtask

   // Behavioural reference state for the randomized phase.
   typedef enum {M_BOOT, M_RUN, M_HALT} mode_t;
   mode_t       m_mode;
   logic [31:0] m_pc;
   int          m_wcnt;
   bit          m_err;

   function automatic logic [31:0] ref_target(logic [31:0] pc, logic [1:0] sel, bit tk,
                                             logic [15:0] off, logic [25:0] idx, logic [31:0] jr);
      longint t;
      case (sel)
         2'b00:   t = longint'(pc) + 4;
         2'b01:   t = tk ? longint'(pc) + 4 + 4 * longint'($signed(off)) : longint'(pc) + 4;
         2'b10:   t = (longint'(pc) / 268435456) * 268435456 + 4 * longint'(idx);
         default: t = longint'(jr);
      endcase
      return 32'(t);
   endfunction

   function automatic bit ref_ok(logic [31:0] t);
      return (t >= IM_BASE) && (longint'(t) < longint'(IM_BASE) + 4 * IM_WORDS) && (t % 4 == 0);
   endfunction

   initial begin
      drive(1, 0, 32'h0, 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h0);

      // Directed table: boot, sequential/branch/jump/jr flow, halts and resets.
      tbl.push_back(v(5'b11000, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b00000, 12'd0, 32'h0,    N));
      tbl.push_back(v(5'b00000, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b10000, 12'd0, 32'h3000, Y));
      tbl.push_back(v(5'b01000, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b11000, 12'd0, 32'h3000, Y));
      tbl.push_back(v(5'b01000, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b11000, 12'd1, 32'h3000, Y));
      tbl.push_back(v(5'b01100, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b11000, 12'd2, 32'h3000, Y));
      tbl.push_back(v(5'b00000, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b00100, 12'd0, 32'h3000, Y));
      tbl.push_back(v(5'b00000, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b00100, 12'd0, 32'h3004, Y));
      tbl.push_back(v(5'b00001, 2'b01, 16'hFFFF, 26'h0,    32'h0,        32'h0,  5'b00100, 12'd0, 32'h3008, Y));
      tbl.push_back(v(5'b00000, 2'b01, 16'hFFFF, 26'h0,    32'h0,        32'h0,  5'b00100, 12'd0, 32'h3008, Y));
      tbl.push_back(v(5'b00010, 2'b10, 16'h0,    26'h0C01, 32'h0,        32'h0,  5'b00100, 12'd0, 32'h300C, Y));
      tbl.push_back(v(5'b00010, 2'b00, 16'h0,    26'h0,    32'h0,        HALT_WORD, 5'b00100, 12'd0, 32'h300C, Y));
      tbl.push_back(v(5'b00000, 2'b10, 16'h0,    26'h0C01, 32'h0,        32'h0,  5'b00100, 12'd0, 32'h300C, Y));
      tbl.push_back(v(5'b00000, 2'b11, 16'h0,    26'h0,    32'h2FFC,     32'h0,  5'b00100, 12'd0, 32'h3004, Y));
      tbl.push_back(v(5'b00000, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b00011, 12'd0, 32'h3004, Y));
      tbl.push_back(v(5'b10000, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b00001, 12'd0, 32'h3004, Y));
      tbl.push_back(v(5'b01100, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b11000, 12'd0, 32'h3000, Y));
      tbl.push_back(v(5'b00000, 2'b11, 16'h0,    26'h0,    32'h2FFC,     HALT_WORD, 5'b00100, 12'd0, 32'h3000, Y));
      tbl.push_back(v(5'b00000, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b00010, 12'd0, 32'h3000, Y));
      tbl.push_back(v(5'b10000, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b00000, 12'd0, 32'h3000, Y));
      tbl.push_back(v(5'b01000, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b11000, 12'd0, 32'h3000, Y));
      tbl.push_back(v(5'b01000, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b11000, 12'd1, 32'h3000, Y));
      tbl.push_back(v(5'b11000, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b00000, 12'd0, 32'h3000, Y));
      tbl.push_back(v(5'b00000, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b10000, 12'd0, 32'h3000, Y));
      tbl.push_back(v(5'b01100, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b11000, 12'd0, 32'h3000, Y));
      tbl.push_back(v(5'b00010, 2'b00, 16'h0,    26'h0,    32'h0,        HALT_WORD, 5'b00100, 12'd0, 32'h3000, Y));
      tbl.push_back(v(5'b00000, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b00100, 12'd0, 32'h3000, Y));
      tbl.push_back(v(5'b00000, 2'b11, 16'h0,    26'h0,    32'h6FFC,     32'h0,  5'b00100, 12'd0, 32'h3004, Y));
      tbl.push_back(v(5'b00000, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b00100, 12'd0, 32'h6FFC, Y));
      tbl.push_back(v(5'b00000, 2'b00, 16'h0,    26'h0,    32'h0,        32'h0,  5'b00011, 12'd0, 32'h6FFC, Y));

      #1;
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].ctl[4], tbl[i].ctl[3], 32'hA500_0000 + 32'(i), tbl[i].ctl[2], tbl[i].ctl[1],
               tbl[i].sel, tbl[i].ctl[0], tbl[i].off, tbl[i].idx, tbl[i].jr, tbl[i].ins);
         @(negedge clk);
         chk($sformatf("table[%0d]", i), tbl[i].ex[4], tbl[i].ex[3], tbl[i].wa, 32'hA500_0000 + 32'(i),
             tbl[i].ex[2], tbl[i].ex[1], tbl[i].ex[0], tbl[i].pc, tbl[i].cpc);
         @(posedge clk); #1;
      end

      // Full-IM boot without loadLast: the word at the top address must end the boot.
      drive(1, 0, 32'h0, 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h0);
      @(posedge clk); #1;
      for (int k = 0; k < IM_WORDS; k++) begin
         drive(0, 1, 32'h5A00_0000 ^ 32'(k), 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h0);
         @(negedge clk);
         chk("full_boot", 1, 1, 12'(k), 32'h5A00_0000 ^ 32'(k), 0, 0, 0, PC_RESET, Y);
         @(posedge clk); #1;
      end
      drive(0, 1, 32'h0, 0, 1, 2'b00, 0, 16'h0, 26'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("full_boot_run", 0, 0, 12'd0, 32'h0, 1, 0, 0, PC_RESET, Y);
      @(posedge clk); #1;

      // Randomized run against the reference model.
      m_mode = M_RUN; m_pc = PC_RESET; m_wcnt = 0; m_err = 0;
      for (int c = 0; c < 3000; c++) begin
         bit          r, lv, ll, st, tk;
         logic [1:0]  sel;
         logic [15:0] off;
         logic [25:0] idx;
         logic [31:0] jr, ins, ld, t;
         r   = (m_mode == M_HALT) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 299) == 0);
         lv  = $urandom_range(0, 3) != 0;
         ll  = $urandom_range(0, 2) == 0;
         ld  = $urandom;
         st  = $urandom_range(0, 3) == 0;
         sel = 2'($urandom_range(0, 3));
         tk  = $urandom_range(0, 1) == 1;
         off = ($urandom_range(0, 2) != 0) ? 16'($urandom_range(0, 600) - 300) : 16'($urandom);
         idx = 26'(32'h0C00 - 50 + $urandom_range(0, 4200));
         jr  = (32'h2FF0 + 4 * $urandom_range(0, 4110)) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
         ins = ($urandom_range(0, 63) == 0) ? HALT_WORD : $urandom;
         drive(r, lv, ld, ll, st, sel, tk, off, idx, jr, ins);
         @(negedge clk);
         chk("random", (m_mode == M_BOOT) && !r, (m_mode == M_BOOT) && !r && lv, 12'(m_wcnt), ld,
             (m_mode == M_RUN) && !r, (m_mode == M_HALT) && !r, m_err, m_pc, Y);
         // Model update for this clock edge.
         if (r) begin
            m_mode = M_BOOT; m_pc = PC_RESET; m_wcnt = 0; m_err = 0;
         end else if (m_mode == M_BOOT) begin
            if (lv) begin
               if (ll || m_wcnt == IM_WORDS - 1) begin
                  m_mode = M_RUN; m_pc = PC_RESET;
               end
               m_wcnt = (m_wcnt + 1) % IM_WORDS;
            end
         end else if (m_mode == M_RUN && !st) begin
            t = ref_target(m_pc, sel, tk, off, idx, jr);
            if (ins == HALT_WORD) m_mode = M_HALT;
            else if (!ref_ok(t)) begin
               m_mode = M_HALT; m_err = 1;
            end else m_pc = t;
         end
         @(posedge clk); #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
